// File: rtl/io_cycle_initiator.sv
// CPU-side initiator for the 120-board I/O bus: one read/write per request, /IOACK handshake.
// Optional strobe timeout with bus error is enabled by defining IO_TIMEOUT_EN.
module io_cycle_initiator #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_berr,
  output logic [ADDR_W-1:0] MA,
  output logic [DATA_W-1:0] MD_out,
  output logic              MD_oe,
  input  logic [DATA_W-1:0] MD_in,
  output logic              RDIO_n,
  output logic              WRIO_n,
  output logic              CS5,
  output logic              CS7,
  input  logic              IOACK_n
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  // Out-of-range parameters fail elaboration on the missing module.
  if (ADDR_W < 15) begin : g_bad_addr_w
    io_cycle_initiator_addr_w_too_small u_bad ();
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    io_cycle_initiator_timeout_out_of_range u_bad ();
  end

  logic [1:0]        r_state;
  logic              r_write;
  logic              r_rsp_valid;
  logic              r_rsp_berr;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_ma;
  logic [DATA_W-1:0] r_md_out;
  logic              r_md_oe;
  logic              r_rdio_n;
  logic              r_wrio_n;
  logic              r_cs5;
  logic              r_cs7;
  logic              w_ack;
  logic              w_rtc_sel;
`ifdef IO_TIMEOUT_EN
  logic [15:0]       r_cnt;
  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);
`endif

  assign w_ack     = ~IOACK_n;
  assign w_rtc_sel = (req_addr[14:11] == 4'b0111);

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_berr  = r_rsp_berr;
  assign MA        = r_ma;
  assign MD_out    = r_md_out;
  assign MD_oe     = r_md_oe;
  assign RDIO_n    = r_rdio_n;
  assign WRIO_n    = r_wrio_n;
  assign CS5       = r_cs5;
  assign CS7       = r_cs7;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_berr  <= 1'b0;
      r_rsp_rdata <= '0;
      r_ma        <= '0;
      r_md_out    <= '0;
      r_md_oe     <= 1'b0;
      r_rdio_n    <= 1'b1;
      r_wrio_n    <= 1'b1;
      r_cs5       <= 1'b0;
      r_cs7       <= 1'b0;
`ifdef IO_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_ma       <= req_addr;
            r_md_out   <= req_wdata;
            r_md_oe    <= req_write;
            r_write    <= req_write;
            r_cs5      <= 1'b1;
            r_cs7      <= w_rtc_sel;
            r_rsp_berr <= 1'b0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_rdio_n <= r_write;
          r_wrio_n <= ~r_write;
`ifdef IO_TIMEOUT_EN
          r_cnt    <= '0;
`endif
          r_state  <= S_STROBE;
        end
        S_STROBE: begin
          // An ack on the terminal-count edge still completes normally.
          if (w_ack) begin
            if (!r_write) r_rsp_rdata <= MD_in;
            r_rdio_n <= 1'b1;
            r_wrio_n <= 1'b1;
            r_cs5    <= 1'b0;
            r_cs7    <= 1'b0;
            r_md_oe  <= 1'b0;
            r_state  <= S_RECOVER;
          end
`ifdef IO_TIMEOUT_EN
          else if (r_cnt == TERM_CNT) begin
            r_rsp_berr <= 1'b1;
            r_rdio_n   <= 1'b1;
            r_wrio_n   <= 1'b1;
            r_cs5      <= 1'b0;
            r_cs7      <= 1'b0;
            r_md_oe    <= 1'b0;
            r_state    <= S_RECOVER;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        default: begin
          // A stale ack still low from the last device must not leak into the next cycle.
          if (!w_ack) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_cycle_initiator.sv
// Directed bench for io_cycle_initiator; timeout scenario runs only when IO_TIMEOUT_EN is defined.
module tb_io_cycle_initiator;

  logic        CLK;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_berr;
  logic [14:0] MA;
  logic [7:0]  MD_out;
  logic        MD_oe;
  logic [7:0]  MD_in;
  logic        RDIO_n;
  logic        WRIO_n;
  logic        CS5;
  logic        CS7;
  logic        IOACK_n;

  int total;
  int bad;

  io_cycle_initiator #(.ADDR_W(15), .DATA_W(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_berr(rsp_berr),
    .MA(MA), .MD_out(MD_out), .MD_oe(MD_oe), .MD_in(MD_in),
    .RDIO_n(RDIO_n), .WRIO_n(WRIO_n), .CS5(CS5), .CS7(CS7), .IOACK_n(IOACK_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #12;
    total++;
    if ({RDIO_n, WRIO_n, CS5, CS7, MD_oe} !== 5'b11000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=11000", {RDIO_n, WRIO_n, CS5, CS7, MD_oe});
    end
    total++;
    if ({MA, MD_out} !== 23'd0) begin
      bad++; $display("FAIL reset_bus got MA=%h MD_out=%h exp=0", MA, MD_out);
    end
    total++;
    if ({req_ready, rsp_valid, rsp_berr, rsp_rdata} !== {3'b100, 8'h00}) begin
      bad++; $display("FAIL reset_rsp got ready=%b v=%b berr=%b rdata=%h exp 1/0/0/00",
                      req_ready, rsp_valid, rsp_berr, rsp_rdata);
    end
    @(negedge CLK);
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_read_parallel();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1800; req_wdata = 8'h00;
    MD_in = 8'hA5;
    tick();  // T0
    req_valid = 1'b0;
    total++;
    if ({req_ready, CS5, CS7, MD_oe, RDIO_n, WRIO_n} !== 6'b010011 || MA !== 15'h1800) begin
      bad++; $display("FAIL rd_setup got rdy/cs5/cs7/oe/rd/wr=%b MA=%h exp=010011 MA=1800",
                      {req_ready, CS5, CS7, MD_oe, RDIO_n, WRIO_n}, MA);
    end
    tick();  // T1
    total++;
    if (RDIO_n !== 1'b0 || WRIO_n !== 1'b1) begin
      bad++; $display("FAIL rd_strobe_t1 got RDIO_n=%b WRIO_n=%b exp 0/1", RDIO_n, WRIO_n);
    end
    tick();  // T2
    IOACK_n = 1'b0;
    total++;
    if (RDIO_n !== 1'b0) begin
      bad++; $display("FAIL rd_strobe_t2 got RDIO_n=%b exp 0", RDIO_n);
    end
    tick();  // T3
    IOACK_n = 1'b1;
    MD_in = 8'h00;
    total++;
    if ({RDIO_n, CS5, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL rd_release got rd/cs5/vld=%b exp=100", {RDIO_n, CS5, rsp_valid});
    end
    tick();  // T4
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_berr !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rd_rsp got v=%b rdata=%h berr=%b rdy=%b exp 1/A5/0/1",
                      rsp_valid, rsp_rdata, rsp_berr, req_ready);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rd_rsp_pulse got v=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_write_rtc();
    int low_ok;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h3800; req_wdata = 8'h3C;
    tick();  // T0
    req_valid = 1'b0;
    total++;
    if ({CS5, CS7, MD_oe, WRIO_n} !== 4'b1111 || MD_out !== 8'h3C) begin
      bad++; $display("FAIL wr_setup got cs5/cs7/oe/wr=%b MD_out=%h exp=1111 3C",
                      {CS5, CS7, MD_oe, WRIO_n}, MD_out);
    end
    tick();  // T1
    low_ok = 0;
    for (int k = 1; k <= 12; k++) begin
      if (WRIO_n === 1'b0 && RDIO_n === 1'b1 && CS7 === 1'b1 && MD_oe === 1'b1 && MD_out === 8'h3C)
        low_ok++;
      if (k == 12) IOACK_n = 1'b0;
      tick();
    end
    IOACK_n = 1'b1;
    total++;
    if (low_ok != 12) begin
      bad++; $display("FAIL wr_strobe_cycles got=%0d exp=12", low_ok);
    end
    total++;
    if ({WRIO_n, CS7, MD_oe} !== 3'b100 || MD_out !== 8'h3C) begin
      bad++; $display("FAIL wr_release got wr/cs7/oe=%b MD_out=%h exp=100 3C", {WRIO_n, CS7, MD_oe}, MD_out);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_berr !== 1'b0 || rsp_rdata !== 8'hA5) begin
      bad++; $display("FAIL wr_rsp got v=%b berr=%b rdata=%h exp 1/0/A5", rsp_valid, rsp_berr, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_stale_ack();
    int early;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0800; req_wdata = 8'h00;
    tick();  // T0
    req_valid = 1'b0;
    tick();  // T1
    IOACK_n = 1'b0;
    MD_in = 8'hC3;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h2800; req_wdata = 8'h99;
    tick();  // T2
    total++;
    if (RDIO_n !== 1'b1) begin
      bad++; $display("FAIL stale_release got RDIO_n=%b exp 1", RDIO_n);
    end
    early = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || CS5 !== 1'b0) early++;
    end
    IOACK_n = 1'b1;
    MD_in = 8'h00;
    total++;
    if (early != 0) begin
      bad++; $display("FAIL stale_hold got early_exits=%0d exp=0", early);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_rdata !== 8'hC3) begin
      bad++; $display("FAIL stale_rsp got v=%b rdy=%b rdata=%h exp 1/1/C3", rsp_valid, req_ready, rsp_rdata);
    end
    tick();
    req_valid = 1'b0;
    total++;
    if (CS5 !== 1'b1 || MA !== 15'h2800 || MD_oe !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL stale_next_accept got cs5=%b MA=%h oe=%b rdy=%b exp 1/2800/1/0",
                      CS5, MA, MD_oe, req_ready);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1000; req_wdata = 8'h00;
    MD_in = 8'h11;
    tick();  // T0
    req_addr = 15'h2000;
    tick();  // T1
    IOACK_n = 1'b0;
    total++;
    if (RDIO_n !== 1'b0) begin
      bad++; $display("FAIL b2b_first_strobe got RDIO_n=%b exp 0", RDIO_n);
    end
    tick();  // T2
    IOACK_n = 1'b1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_recover got rdy=%b v=%b exp 0/0", req_ready, rsp_valid);
    end
    tick();  // T3
    MD_in = 8'h5A;
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_rdata !== 8'h11) begin
      bad++; $display("FAIL b2b_rsp1 got v=%b rdy=%b rdata=%h exp 1/1/11", rsp_valid, req_ready, rsp_rdata);
    end
    tick();  // T4
    req_valid = 1'b0;
    total++;
    if (MA !== 15'h2000 || {CS5, RDIO_n, req_ready, rsp_valid} !== 4'b1100) begin
      bad++; $display("FAIL b2b_accept2 got MA=%h cs5/rd/rdy/v=%b exp 2000 1100",
                      MA, {CS5, RDIO_n, req_ready, rsp_valid});
    end
    tick();  // T5
    IOACK_n = 1'b0;
    total++;
    if (RDIO_n !== 1'b0) begin
      bad++; $display("FAIL b2b_second_strobe got RDIO_n=%b exp 0", RDIO_n);
    end
    tick();  // T6
    IOACK_n = 1'b1;
    tick();  // T7
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_berr !== 1'b0) begin
      bad++; $display("FAIL b2b_rsp2 got v=%b rdata=%h berr=%b exp 1/5A/0", rsp_valid, rsp_rdata, rsp_berr);
    end
    tick();
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    int low;
    int seen;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0000; req_wdata = 8'h00;
    IOACK_n = 1'b1;
    MD_in = 8'hEE;
    tick();
    req_valid = 1'b0;
    low = 0;
    seen = 0;
    for (int k = 0; k < 64 && seen == 0; k++) begin
      tick();
      if (RDIO_n === 1'b0) low++;
      if (rsp_valid === 1'b1) seen = 1;
    end
    total++;
    if (seen == 0) begin
      bad++; $display("FAIL to_rsp_timeout got no rsp_valid within 64 cycles exp rsp_valid");
    end
    total++;
    if (low != 16) begin
      bad++; $display("FAIL to_strobe_cycles got=%0d exp=16", low);
    end
    total++;
    if (rsp_berr !== 1'b1 || rsp_rdata !== 8'h5A) begin
      bad++; $display("FAIL to_berr got berr=%b rdata=%h exp 1/5A", rsp_berr, rsp_rdata);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_cycle();
    int spurious;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0000; req_wdata = 8'h77;
    tick();  // T0
    req_valid = 1'b0;
    total++;
    if (rsp_berr !== 1'b0) begin
      bad++; $display("FAIL mid_berr_clear got berr=%b exp 0", rsp_berr);
    end
    tick();  // T1
    total++;
    if (WRIO_n !== 1'b0) begin
      bad++; $display("FAIL mid_strobe got WRIO_n=%b exp 0", WRIO_n);
    end
    tick();
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({WRIO_n, CS5, MD_oe} !== 3'b100 || MD_out !== 8'h00) begin
      bad++; $display("FAIL mid_async got wr/cs5/oe=%b MD_out=%h exp=100 00", {WRIO_n, CS5, MD_oe}, MD_out);
    end
    #3 RESET = 1'b0;
    spurious = 0;
    IOACK_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || WRIO_n !== 1'b1) spurious++;
    end
    IOACK_n = 1'b1;
    total++;
    if (spurious != 0) begin
      bad++; $display("FAIL mid_no_rsp got spurious=%0d exp=0", spurious);
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready got rdy=%b exp 1", req_ready);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    MD_in = '0; IOACK_n = 1'b1;
    test_reset();
    test_read_parallel();
    test_write_rtc();
    test_stale_ack();
    test_back_to_back();
`ifdef IO_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
